neuron_mac_accumulator: RTL and testbench

//  Serial multiply-accumulate engine that produces the 21-bit signed pre-activation
//  sum consumed by the activation stage. Takes N_INPUTS (activation, weight) byte

---
 rtl/neuron_mac_accumulator_if.sv | 25 ++
 rtl/neuron_mac_accumulator.sv | 107 ++++++++++
 tb/tb_neuron_mac_accumulator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_accumulator_if.sv
// Stream bundle between the input buffer/weight ROM, one neuron's MAC engine
// and its activation stage.
`timescale 1ns/1ps
interface neuron_mac_accumulator_if;
  logic               start;
  logic signed [20:0] bias;
  logic signed [7:0]  x;
  logic signed [7:0]  w;
  logic               in_valid;
  logic               in_ready;
  logic signed [20:0] acc_out;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output start, bias, x, w, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, busy
  );

  modport slave (
    input  start, bias, x, w, in_valid, out_ready,
    output in_ready, acc_out, out_valid, busy
  );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Serial saturating multiply-accumulate for one neuron: bias plus N_INPUTS signed
// byte products, presented as a 21-bit pre-activation sum over valid/ready.
`timescale 1ns/1ps
module neuron_mac_accumulator #(
  parameter int N_INPUTS = 32,
  parameter int CNT_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_mac_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic signed [20:0] SAT_MAX = 21'sh0FFFFF;
  localparam logic signed [20:0] SAT_MIN = 21'sh100000;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(N_INPUTS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic signed [20:0] r_acc;
  logic [CNT_W-1:0]   r_count;

  logic signed [15:0] w_prod;
  logic signed [21:0] w_sum;
  logic signed [20:0] w_sat;
  logic               w_beat;
  logic               w_last;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;
  logic signed [20:0] w_acc_out;

  assign w_prod = bus.x * bus.w;
  assign w_sum  = {r_acc[20], r_acc} + {{6{w_prod[15]}}, w_prod};

  // Bits 21 and 20 disagree only when the 22-bit sum left the 21-bit range.
  always_comb begin
    w_sat = w_sum[20:0];
    if (w_sum[21] != w_sum[20]) begin
      w_sat = w_sum[21] ? SAT_MIN : SAT_MAX;
    end
  end

  assign w_beat = bus.in_valid && (r_state == S_ACCUM);
  assign w_last = w_beat && (r_count == LAST_BEAT);

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    w_acc_out    = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
        w_acc_out   = r_acc;
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && bus.start) begin
        r_acc   <= bus.bias;
        r_count <= '0;
      end else if (w_beat) begin
        r_acc   <= w_sat;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.acc_out   = w_acc_out;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Bench for neuron_mac_accumulator: table of full evaluations with known sums,
// randomized evaluations against an arithmetic model, plus reset/chaining corners.
`timescale 1ns/1ps
module tb_neuron_mac_accumulator;
  localparam int N = 32;

  localparam int P_ONES = 0;
  localparam int P_ALT  = 1;
  localparam int P_MAX  = 2;
  localparam int P_MIN  = 3;
  localparam int P_23   = 4;

  typedef struct {
    int bias;
    int pattern;
    int gap_pct;
    int hold;
    bit noise;
    bit retire_start;
    bit chk_lat;
    int expected;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   beat_x [N];
  int   beat_w [N];
  vec_t vecs [7];

  neuron_mac_accumulator_if bus();

  neuron_mac_accumulator #(.N_INPUTS(N), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic fill_pattern(input int p);
    for (int i = 0; i < N; i++) begin
      case (p)
        P_ONES:  begin beat_x[i] = 1;    beat_w[i] = 1;   end
        P_ALT:   begin
          beat_x[i] = (i % 2 == 0) ? -128 : 5;
          beat_w[i] = (i % 2 == 0) ? 127  : -3;
        end
        P_MAX:   begin beat_x[i] = 127;  beat_w[i] = 127; end
        P_MIN:   begin beat_x[i] = -128; beat_w[i] = 127; end
        default: begin beat_x[i] = 2;    beat_w[i] = 3;   end
      endcase
    end
  endtask

  // Sum of products with clamping applied after every addition.
  function automatic int model_sum(input int bias);
    int acc = bias;
    for (int i = 0; i < N; i++) begin
      acc = acc + beat_x[i] * beat_w[i];
      if (acc > 1048575)  acc = 1048575;
      if (acc < -1048576) acc = -1048576;
    end
    return acc;
  endfunction

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.x         = '0;
    bus.w         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_eval(input string name, input int bias, input int gap_pct,
                          input int hold, input bit noise, input bit retire_start,
                          input bit chk_lat, input int expected);
    int lat;
    int idx;
    int cyc;
    int waitc;
    int first;
    bit stable;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bias  = 21'(bias);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 1000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.x = 8'($urandom);
        bus.w = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.x = 8'(beat_x[idx]);
        bus.w = 8'(beat_w[idx]);
        if (bus.in_ready) idx++;
      end
      if (noise) begin
        bus.start     = 1'($urandom_range(1));
        bus.bias      = 21'($urandom);
        bus.out_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      lat++;
      cyc++;
    end
    idle_inputs();
    check({name, " beats_accepted"}, idx, N);
    if (chk_lat) check({name, " latency"}, lat, N + 1);
    waitc = 0;
    while (!bus.out_valid && waitc < 8) begin
      @(negedge clk);
      waitc++;
    end
    check({name, " out_valid"}, int'(bus.out_valid), 1);
    check({name, " acc_out"}, int'(bus.acc_out), expected);
    first  = int'(bus.acc_out);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        bus.start    = 1'b1;
        bus.bias     = 21'($urandom);
        bus.in_valid = 1'b1;
        bus.x        = 8'($urandom);
        bus.w        = 8'($urandom);
      end
      @(negedge clk);
      if (int'(bus.acc_out) != first || bus.out_valid !== 1'b1) stable = 1'b0;
    end
    check({name, " held_stable"}, int'(stable), 1);
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.start     = retire_start;
    @(negedge clk);
    idle_inputs();
    check({name, " retired_out_valid"}, int'(bus.out_valid), 0);
    check({name, " retired_acc_out"}, int'(bus.acc_out), 0);
    check({name, " retired_busy"}, int'(bus.busy), 0);
    if (retire_start) begin
      @(negedge clk);
      check({name, " no_chain_busy"}, int'(bus.busy), 0);
    end
    $display("eval %s: bias=%0d acc_out=%0d expected=%0d", name, bias, first, expected);
  endtask

  initial begin
    int rb;
    vecs[0] = '{10,       P_ONES, 0,  5, 1'b0, 1'b0, 1'b1, 42};
    vecs[1] = '{0,        P_ALT,  0,  1, 1'b0, 1'b0, 1'b1, -260336};
    vecs[2] = '{1048000,  P_MAX,  0,  0, 1'b0, 1'b0, 1'b1, 1048575};
    vecs[3] = '{-1048000, P_MIN,  0,  0, 1'b0, 1'b0, 1'b1, -1048576};
    vecs[4] = '{10,       P_ONES, 40, 5, 1'b0, 1'b0, 1'b0, 42};
    vecs[5] = '{0,        P_ALT,  30, 3, 1'b1, 1'b0, 1'b0, -260336};
    vecs[6] = '{0,        P_23,   0,  2, 1'b0, 1'b1, 1'b1, 192};

    idle_inputs();
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_ready", int'(bus.in_ready), 0);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset acc_out", int'(bus.acc_out), 0);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", int'(bus.busy), 0);

    for (int v = 0; v < 7; v++) begin
      fill_pattern(vecs[v].pattern);
      run_eval($sformatf("vec%0d", v), vecs[v].bias, vecs[v].gap_pct, vecs[v].hold,
               vecs[v].noise, vecs[v].retire_start, vecs[v].chk_lat, vecs[v].expected);
    end

    for (int r = 0; r < 6; r++) begin
      rb = int'($urandom_range(0, 2097151)) - 1048576;
      for (int i = 0; i < N; i++) begin
        beat_x[i] = int'($urandom_range(0, 255)) - 128;
        beat_w[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_eval($sformatf("rand%0d", r), rb, 25 * (r % 3), r, r[0], 1'b0, 1'b0,
               model_sum(rb));
    end

    // Abort an evaluation after 10 accepted beats; reset must beat simultaneous start.
    fill_pattern(P_ALT);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bias  = 21'(12345);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.x = 8'(beat_x[0]);
    bus.w = 8'(beat_w[0]);
    repeat (10) @(negedge clk);
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    check("abort busy", int'(bus.busy), 0);
    check("abort in_ready", int'(bus.in_ready), 0);
    check("abort out_valid", int'(bus.out_valid), 0);
    check("abort acc_out", int'(bus.acc_out), 0);
    @(negedge clk);
    check("abort stays_idle", int'(bus.busy), 0);
    fill_pattern(P_23);
    run_eval("after_abort", 0, 0, 1, 1'b0, 1'b0, 1'b1, 192);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
